// File: rtl/echo_request_input_pkg.sv
// EchoRequest word layout and tag codes.
// Shared with the request serializer so both sides agree on the format.
package before1;

   localparam logic [31:0] TAG_SAY  = 32'd1;
   localparam logic [31:0] TAG_SAY2 = 32'd2;

   typedef struct packed {
      logic [31:0] meth;
      logic [31:0] v;
   } say_t;

   typedef struct packed {
      logic [31:0] pad;
      logic [15:0] meth;
      logic [15:0] v;
   } say2_t;

   typedef union packed {
      say_t  say;
      say2_t say2;
   } echo_union_t;

   typedef struct packed {
      logic [31:0] tag;
      echo_union_t data;
   } EchoRequest_data;

   localparam int unsigned WORD_W = $bits(EchoRequest_data);

   typedef enum logic [1:0] {
      FIFO_EMPTY = 2'd0,
      FIFO_ONE   = 2'd1,
      FIFO_FULL  = 2'd2
   } fifo_state_e;

   typedef enum logic [1:0] {
      KIND_NONE = 2'd0,
      KIND_SAY  = 2'd1,
      KIND_SAY2 = 2'd2,
      KIND_BAD  = 2'd3
   } tag_kind_e;

   function automatic tag_kind_e decode_tag(input logic [31:0] tag);
      tag_kind_e k;
      case (tag)
         TAG_SAY:  k = KIND_SAY;
         TAG_SAY2: k = KIND_SAY2;
         default:  k = KIND_BAD;
      endcase
      return k;
   endfunction

endpackage

// File: rtl/echo_request_input_if.sv
// Transport-side enqueue port and client-side method port
// of the EchoRequest pipe.
interface pipe_in_if;
  import before1::*;

  logic            enq__ENA;
  EchoRequest_data enq_v;
  logic            enq__RDY;

  modport master (
    output enq__ENA,
    output enq_v,
    input  enq__RDY
  );

  modport slave (
    input  enq__ENA,
    input  enq_v,
    output enq__RDY
  );
endinterface

interface echo_request_if;
  logic        say__ENA;
  logic [31:0] say_meth;
  logic [31:0] say_v;
  logic        say__RDY;
  logic        say2__ENA;
  logic [15:0] say2_meth;
  logic [15:0] say2_v;
  logic        say2__RDY;

  modport master (
    output say__ENA,
    output say_meth,
    output say_v,
    input  say__RDY,
    output say2__ENA,
    output say2_meth,
    output say2_v,
    input  say2__RDY
  );

  modport slave (
    input  say__ENA,
    input  say_meth,
    input  say_v,
    output say__RDY,
    input  say2__ENA,
    input  say2_meth,
    input  say2_v,
    output say2__RDY
  );
endinterface

// File: rtl/echo_request_input_fifo2.sv
// Two-entry FIFO with a registered head and no flow-through.
// slot0 always holds the head; slot1 holds the second word when full.
module echo_pipe_fifo2 #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enq,
   input  logic [WIDTH-1:0] enq_data,
   input  logic             deq,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);
   import before1::*;

   fifo_state_e      state;
   fifo_state_e      state_next;
   logic [WIDTH-1:0] slot0;
   logic [WIDTH-1:0] slot1;
   logic             enq_fire;
   logic             deq_fire;

   assign full     = (state == FIFO_FULL);
   assign empty    = (state == FIFO_EMPTY);
   assign enq_fire = enq && !full;
   assign deq_fire = deq && !empty;
   assign head     = slot0;

   // occupancy register
   always_ff @(posedge clk) begin
      if (rst) state <= FIFO_EMPTY;
      else     state <= state_next;
   end

   // next occupancy from the enqueue/dequeue pair
   always_comb begin
      state_next = state;
      case (state)
         FIFO_EMPTY: begin
            if (enq_fire) state_next = FIFO_ONE;
         end
         FIFO_ONE: begin
            if (enq_fire && !deq_fire)
               state_next = FIFO_FULL;
            else if (!enq_fire && deq_fire)
               state_next = FIFO_EMPTY;
         end
         FIFO_FULL: begin
            if (deq_fire) state_next = FIFO_ONE;
         end
         default: state_next = FIFO_EMPTY;
      endcase
   end

   // data slots; a simultaneous push/pop at one entry replaces the head
   always_ff @(posedge clk) begin
      if (rst) begin
         slot0 <= '0;
         slot1 <= '0;
      end else begin
         case (state)
            FIFO_EMPTY: begin
               if (enq_fire) slot0 <= enq_data;
            end
            FIFO_ONE: begin
               if (enq_fire && deq_fire)
                  slot0 <= enq_data;
               else if (enq_fire)
                  slot1 <= enq_data;
            end
            FIFO_FULL: begin
               if (deq_fire) slot0 <= slot1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/echo_request_input.sv
// EchoRequest pipe receiver: buffers tagged words and dispatches
// them as say/say2 calls; unknown tags are dropped and counted.
module echo_request_input
  import before1::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  pipe_in_if.slave         pipe,
  echo_request_if.master   request,
  output logic [CNT_W-1:0] bad_tag_cnt
);

  if (DEPTH != 2) begin : g_depth_check
    $error("echo_request_input supports DEPTH == 2 only");
  end

  EchoRequest_data head;
  logic            full;
  logic            empty;
  logic            deq;
  logic            drop;
  tag_kind_e       kind;

  echo_pipe_fifo2 #(
    .WIDTH(WORD_W)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RST),
    .enq     (pipe.enq__ENA),
    .enq_data(pipe.enq_v),
    .deq     (deq),
    .full    (full),
    .empty   (empty),
    .head    (head)
  );

  assign pipe.enq__RDY = !RST && !full;
  assign deq = request.say__ENA
            || request.say2__ENA
            || drop;

  always_comb begin
    kind = KIND_NONE;
    if (!empty) kind = decode_tag(head.tag);
  end

  always_comb begin
    request.say__ENA  = 1'b0;
    request.say2__ENA = 1'b0;
    drop              = 1'b0;
    if (!RST) begin
      case (kind)
        KIND_SAY:  request.say__ENA  = request.say__RDY;
        KIND_SAY2: request.say2__ENA = request.say2__RDY;
        KIND_BAD:  drop              = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    request.say_meth  = '0;
    request.say_v     = '0;
    request.say2_meth = '0;
    request.say2_v    = '0;
    if (kind == KIND_SAY) begin
      request.say_meth = head.data.say.meth;
      request.say_v    = head.data.say.v;
    end
    if (kind == KIND_SAY2) begin
      request.say2_meth = head.data.say2.meth;
      request.say2_v    = head.data.say2.v;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST)
      bad_tag_cnt <= '0;
    else if (drop && !(&bad_tag_cnt))
      bad_tag_cnt <= bad_tag_cnt + 1'b1;
  end

endmodule

// File: tb/tb_echo_request_input.sv
// Randomized scoreboard bench for echo_request_input.
// A queue-level model tracks buffered words and the drop count.
module tb_echo_request_input;
  import before1::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] bad_tag_cnt;

  pipe_in_if      pipe();
  echo_request_if request();

  echo_request_input #(
    .DEPTH(2),
    .CNT_W(16)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .pipe       (pipe),
    .request    (request),
    .bad_tag_cnt(bad_tag_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          kind;
    logic [31:0] meth;
    logic [31:0] v;
  } exp_t;

  logic [95:0] occ[$];
  exp_t        sb[$];
  int          exp_bad = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h @%0t",
               name, act, req, $time);
    end
  endtask

  always @(negedge CLK) begin : model
    logic [31:0] t;
    logic [31:0] e_sm, e_sv;
    logic [15:0] e_2m, e_2v;
    bit          m_rdy, m_say, m_say2, m_drop;
    t = '0; e_sm = '0; e_sv = '0; e_2m = '0; e_2v = '0;
    m_say = 0; m_say2 = 0; m_drop = 0;
    m_rdy = !RST && (occ.size() < 2);
    if (occ.size() > 0) begin
      t = occ[0][95:64];
      if (t == 32'd1) begin
        e_sm = occ[0][63:32];
        e_sv = occ[0][31:0];
      end else if (t == 32'd2) begin
        e_2m = occ[0][31:16];
        e_2v = occ[0][15:0];
      end
      if (!RST) begin
        if (t == 32'd1)      m_say  = request.say__RDY;
        else if (t == 32'd2) m_say2 = request.say2__RDY;
        else                 m_drop = 1;
      end
    end
    chk("enq_rdy", 64'(pipe.enq__RDY), 64'(m_rdy));
    chk("say_ena", 64'(request.say__ENA), 64'(m_say));
    chk("say2_ena", 64'(request.say2__ENA), 64'(m_say2));
    chk("bad_cnt", 64'(bad_tag_cnt), 64'(exp_bad));
    chk("say_meth", 64'(request.say_meth), 64'(e_sm));
    chk("say_v", 64'(request.say_v), 64'(e_sv));
    chk("say2_meth", 64'(request.say2_meth), 64'(e_2m));
    chk("say2_v", 64'(request.say2_v), 64'(e_2v));
    if (RST) begin
      occ.delete();
      sb.delete();
      exp_bad = 0;
    end else begin
      if (m_say || m_say2 || m_drop) void'(occ.pop_front());
      if (m_drop && exp_bad != 65535) exp_bad++;
      if (pipe.enq__ENA) occ.push_back(pipe.enq_v);
    end
  end

  always @(negedge CLK) begin : monitor
    exp_t e;
    if (request.say__ENA || request.say2__ENA) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_ena: got say=%0b say2=%0b required none",
                 request.say__ENA, request.say2__ENA);
      end else begin
        e = sb.pop_front();
        if (request.say2__ENA) begin
          chk("call_kind", 64'd2, 64'(e.kind));
          chk("call_meth", 64'(request.say2_meth), 64'(e.meth));
          chk("call_v", 64'(request.say2_v), 64'(e.v));
        end else begin
          chk("call_kind", 64'd1, 64'(e.kind));
          chk("call_meth", 64'(request.say_meth), 64'(e.meth));
          chk("call_v", 64'(request.say_v), 64'(e.v));
        end
      end
    end
  end

  task automatic cyc(input bit ena, input logic [31:0] tag,
                     input logic [31:0] a, input logic [31:0] b,
                     input bit sr, input bit s2r, input bit rst);
    exp_t e;
    bit   go;
    @(posedge CLK);
    #1;
    go = ena && !rst && (occ.size() < 2);
    RST               = rst;
    pipe.enq__ENA     = go;
    pipe.enq_v        = {tag, a, b};
    request.say__RDY  = sr;
    request.say2__RDY = s2r;
    if (go && (tag == 32'd1 || tag == 32'd2)) begin
      e.kind = int'(tag);
      e.meth = (tag == 32'd1) ? a : {16'd0, b[31:16]};
      e.v    = (tag == 32'd1) ? b : {16'd0, b[15:0]};
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n, input bit sr, input bit s2r);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, sr, s2r, 0);
  endtask

  initial begin
    pipe.enq__ENA     = 1'b0;
    pipe.enq_v        = '0;
    request.say__RDY  = 1'b0;
    request.say2__RDY = 1'b0;
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    idle(2, 1, 1);

    cyc(1, 1, 32'h11, 32'h22, 1, 1, 0);
    idle(3, 1, 1);

    cyc(1, 1, 32'hA1, 32'hB1, 1, 1, 0);
    cyc(1, 2, 32'h0, 32'h1234_5678, 1, 1, 0);
    cyc(1, 1, 32'hA3, 32'hB3, 1, 1, 0);
    idle(3, 1, 1);

    cyc(1, 1, 32'hC1, 32'hD1, 0, 1, 0);
    cyc(1, 1, 32'hC2, 32'hD2, 0, 1, 0);
    cyc(1, 1, 32'hC3, 32'hD3, 0, 1, 0);
    idle(2, 0, 1);
    idle(4, 1, 1);

    cyc(1, 0, 32'h1, 32'h2, 1, 1, 0);
    cyc(1, 7, 32'h3, 32'h4, 1, 1, 0);
    cyc(1, 2, 32'h0, 32'hBEEF_CAFE, 1, 1, 0);
    idle(3, 1, 1);

    cyc(1, 1, 32'hE1, 32'hF1, 0, 0, 0);
    cyc(1, 2, 32'hE2, 32'hF2, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    idle(4, 1, 1);

    for (int i = 0; i < 800; i++) begin
      int          r;
      logic [31:0] tg;
      r  = $urandom_range(0, 9);
      tg = (r < 4) ? 32'd1 : (r < 8) ? 32'd2 :
           (r == 8) ? 32'd0 : $urandom;
      cyc($urandom_range(0, 3) != 0, tg, $urandom, $urandom,
          $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
          $urandom_range(0, 199) == 0);
    end
    idle(4, 1, 1);

    for (int i = 0; i < 65600; i++)
      cyc(1, 32'hDEAD_0000, 0, 0, 1, 1, 0);
    idle(3, 1, 1);
    chk("bad_sat", 64'(bad_tag_cnt), 64'hFFFF);

    for (int i = 0; i < 20 && sb.size() > 0; i++) idle(1, 1, 1);
    idle(2, 1, 1);
    chk("drain_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/echo_request_input.md
# echo_request_input

Receive side of the EchoRequest pipe: accepts tagged, packed `EchoRequest_data` words from the `PipeIn` transport and dispatches each one as a `say` or `say2` method call on the downstream `EchoRequest` client. Sits directly downstream of the request serializer and the pipe transport, and upstream of the echo application logic. Buffers two words so that the transport can keep streaming while the consumer stalls. Drops and counts words whose tag is unknown.

## Interface
Parameters:
- `DEPTH`, 2: buffer entries. Fixed at 2; any other value is unsupported.
- `CNT_W`, 16: width of the bad-tag counter.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `CLK`  in  1  clock.
- `RST`  in  1  synchronous, active-high reset.
- `pipe.enq__ENA`  in  1  producer writes `pipe.enq$v` this cycle. Legal only while `pipe.enq__RDY` is 1.
- `pipe.enq$v`  in  96  `EchoRequest_data` word. Bits [95:64] are the tag; bits [63:0] are the data union.
- `pipe.enq__RDY`  out  1  buffer not full.
- `request.say__ENA`  out  1  issue `say`.
- `request.say$meth`  out  32  `say` argument `meth`, taken from union [63:32].
- `request.say$v`  out  32  `say` argument `v`, taken from union [31:0].
- `request.say__RDY`  in  1  consumer can accept `say`.
- `request.say2__ENA`  out  1  issue `say2`.
- `request.say2$meth`  out  16  `say2` argument `meth`, taken from union [31:16].
- `request.say2$v`  out  16  `say2` argument `v`, taken from union [15:0].
- `request.say2__RDY`  in  1  consumer can accept `say2`.
- `bad_tag_cnt`  out  `CNT_W`  saturating count of dropped words.

## Operation
- Tags: `TAG_SAY`=1, `TAG_SAY2`=2. Every other value is invalid, including 0.
- Buffer: 2-entry FIFO with registered head and occupancy `cnt` in {0,1,2}.
- Enqueue fire: `pipe.enq__ENA && pipe.enq__RDY`.
- `pipe.enq__RDY` = `cnt != 2`. A full buffer has no bypass, even if a dequeue happens in the same cycle.
- Head dispatch, only when `cnt != 0`:
  - Tag 1: `say__ENA` = `say__RDY`. Arguments are driven from the head whenever the head tag is 1; otherwise they are 0.
  - Tag 2: `say2__ENA` = `say2__RDY`. Arguments are handled the same way as for tag 1.
  - Invalid tag: the word pops unconditionally that cycle and `bad_tag_cnt` increments. The counter saturates at all-ones.
- An ENA is never asserted without its matching RDY. `say__ENA` and `say2__ENA` are never both 1.
- Dequeue fire: a method ENA, or an invalid-tag drop.
- Simultaneous enqueue and dequeue at `cnt`=1: the new word becomes the head and `cnt` stays 1.
- A word enqueued at `cnt`=0 is not visible until the next cycle; there is no flow-through.
- Ordering is strict FIFO. A stalled head blocks every later word, including invalid ones.

## Timing
- Reset:
  - `cnt`=0 and `bad_tag_cnt`=0.
  - `pipe.enq__RDY`=1 in the first cycle after reset. During reset it is 0, because `RST` gates it.
  - Both ENAs and all argument outputs are 0.
- Reset mid-operation discards all buffered words. No ENA fires in the reset cycle.
- Latency: an enqueue at cycle N gives the earliest ENA at cycle N+1.
- Throughput: 1 word per cycle sustained while the consumer RDY stays high.
- The outputs `say__ENA` and `say2__ENA` depend combinationally on the RDY inputs. All other outputs are registered-state only.
- Backpressure: with RDY low, 2 words are accepted, then `pipe.enq__RDY` falls the cycle after the second enqueue.

## Structure
- Package `before1` holds:
  - the `EchoRequest_data` packed typedef: tag plus union of the `say` and `say2` structs;
  - `TAG_SAY` and `TAG_SAY2`.
- This package is shared with the serializer so that the two sides cannot drift.
- Sub-module `echo_pipe_fifo2` implements the generic 2-entry FIFO:
  - `enq`/`deq` handshake, `full`/`empty` flags, and `head` output;
  - width is a parameter.
- `echo_request_input` itself contains only tag decode, dispatch, and the counter.

## Test plan
- Single `say`: enqueue tag 1, meth 0x11, v 0x22 with RDY=1. Required: `say__ENA`=1 one cycle later with meth 0x11 and v 0x22, and `cnt` returns to 0.
- Back-to-back mixed stream: tag 1, tag 2, tag 1 on consecutive cycles with both RDYs high. Required: ENAs fire on three consecutive cycles, in order `say`, `say2`, `say`.
- Backpressure: `say__RDY`=0, then 3 enqueue attempts. Required: 2 accepted and `pipe.enq__RDY`=0; after RDY rises, 2 dispatches in order, then RDY returns to 1.
- Invalid tags: enqueue tags 0 and 7, then tag 2. Required: `bad_tag_cnt`=2, no ENA for the first two words, then `say2__ENA` fires.
- Counter saturation: force 0xFFFF bad tags, then one more. Required: `bad_tag_cnt` stays 0xFFFF.
- Reset mid-stream: `RST` asserted with `cnt`=2 and RDY low. Required: next cycle `cnt`=0 and `pipe.enq__RDY`=1, and no stale ENA after RDY rises.
